chip8_alu_exec: RTL
===================

Name: chip8_alu_exec

Overview:
Sequencer for CHIP-8 8XYN register-to-register instructions. It sits between the decoder and the combinational CHIP-8 ALU, and owns the register-file port while an 8XYN is executing. On a start pulse it reads Vx and Vy, drives the ALU operands and operation code, then writes the result to Vx. For flag-producing ops it also writes the ALU carry/borrow to VF, then signals done.

Parameters:
VF_ADDR, 4'hF, register-file index of the flag register
SUBN_EN, 1, 1 = support 8XY7 (Vy-Vx) by swapping ALU operands; 0 = treat N=7 as illegal

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
op_x  in  4  X nibble of opcode
op_y  in  4  Y nibble of opcode
op_n  in  4  N nibble of opcode
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at end of instruction
error  out  1  high together with done when N is illegal
rf_addr  out  4  register-file address
rf_we  out  1  register-file write enable
rf_wdata  out  8  register-file write data
rf_rdata  in  8  register-file read data; synchronous read, valid the cycle after rf_addr is presented
alu_x  out  8  ALU X operand
alu_y  out  8  ALU Y operand
alu_op  out  3  ALU operation: 0 Y, 1 OR, 2 AND, 3 XOR, 4 ADD, 5 SUB, 6 SHR, 7 SHL
alu_out  in  8  ALU result (combinational)
alu_carry  in  1  ALU carry/borrow/shifted-out bit

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0. State = IDLE. Latched x/y/n, operand and flag registers all 0.
- Reset asserted mid-instruction aborts it immediately: no further rf_we, no done.
- N decode to alu_op:
  - N = 0..6 map directly to alu_op 0..6.
  - N = E maps to alu_op 7.
  - N = 7 (SUBN_EN=1) maps to alu_op 5 with alu_x = Vy and alu_y = Vx.
  - All other N are illegal.
- Flag ops are N = 4, 5, 6, 7, E. N = 0..3 never write VF.
- States and transitions:
  - IDLE: when start=1, latch op_x/op_y/op_n. Go to DONE if N is illegal, else go to RD_X. start while busy is ignored and not queued.
  - RD_X: rf_addr = x. Next state RD_Y.
  - RD_Y: rf_addr = y; capture rf_rdata into reg_vx. Next state CAP_Y.
  - CAP_Y: capture rf_rdata into reg_vy. Next state WB_X.
  - WB_X: alu_x/alu_y/alu_op are driven from registers, stable from this cycle. Drive rf_we=1, rf_addr=x, rf_wdata=alu_out. Latch alu_carry into the flag register. Next state WB_F for flag ops, else DONE.
  - WB_F: rf_we=1, rf_addr=VF_ADDR, rf_wdata={7'b0, flag}. Next state DONE.
  - DONE: done=1 for one cycle; error=1 if N was illegal. Next state IDLE.
- Latency, start cycle = 0:
  - Non-flag op: done in cycle 5.
  - Flag op: done in cycle 6.
  - Illegal N: done in cycle 1, with no rf_we in any cycle.
- Write ordering: Vx is written before VF. When x = VF_ADDR, VF's final value is the flag.
- x == y is legal: both reads return the same register.
- Arithmetic rules:
  - All results are 8-bit wrap-around.
  - SUB flag is X > Y strictly, as produced by the ALU; equal operands give flag 0.
  - SHR/SHL operate on Vx only; Vy is read but unused.
- rf_we is high only in WB_X and WB_F. rf_addr holds its last value outside the RD/WB states.
- alu_x/alu_y/alu_op hold their last values until the next instruction reaches WB_X.

Test Plan:
- 8124, V1=0xF0, V2=0x20 -> cycle 4: write V1=0x10; cycle 5: write VF=0x01; done in cycle 6, error=0.
- 8345, V3=0x10, V4=0x10 -> V3=0x00, VF=0x00 (equal operands give no flag); then V3=0x11, V4=0x10 -> V3=0x01, VF=0x01.
- 8567, V5=0x05, V6=0x09 -> alu_op=5, alu_x=0x09, alu_y=0x05; V5=0x04, VF=0x01. With SUBN_EN=0 -> done+error in cycle 1, no rf_we.
- 8F0E, VF=0x81 -> write VF=0x02 then VF=0x01; final VF=0x01. 8122, V1=0x3C, V2=0x0F -> V1=0x0C, VF untouched, done in cycle 5.
- 812B (illegal N) -> done=1, error=1 in cycle 1, rf_we never asserted. A start pulse during a busy 8124 is ignored: exactly one done is seen.
- rst_n driven low in cycle 3 of an 8124 -> all outputs 0 asynchronously. No write to V1/VF and no done after rst_n rises. A new start then executes normally.

Source files
------------

// File: rtl/chip8_alu_exec.sv
// Sequencer for CHIP-8 8XYN register-to-register instructions.
// Owns the register-file port while an 8XYN executes: reads Vx and Vy,
// presents operands to the external combinational ALU, writes the result
// back to Vx and, for flag-producing ops, the carry/borrow to VF.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; latches x/y/n on start
// RD_X    | rf_addr = x, Vx read in flight
// RD_Y    | rf_addr = y, Vx captured
// CAP_Y   | Vy arrives; ALU operand/op registers loaded
// WB_X    | write alu_out to Vx, latch alu_carry into flag
// WB_F    | write {7'b0, flag} to VF
// DONE    | one-cycle done pulse, error if N was illegal
module chip8_alu_exec #(
    parameter logic [3:0] VF_ADDR = 4'hF,
    parameter bit         SUBN_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] op_x,
    input  logic [3:0] op_y,
    input  logic [3:0] op_n,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] rf_addr,
    output logic       rf_we,
    output logic [7:0] rf_wdata,
    input  logic [7:0] rf_rdata,
    output logic [7:0] alu_x,
    output logic [7:0] alu_y,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_out,
    input  logic       alu_carry
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_X  = 3'd1,
        S_RD_Y  = 3'd2,
        S_CAP_Y = 3'd3,
        S_WB_X  = 3'd4,
        S_WB_F  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t     state, state_d;
    logic [3:0] x_q, y_q, n_q;
    logic [7:0] reg_vx;
    logic       flag_q;
    logic [7:0] alu_x_q, alu_y_q;
    logic [2:0] alu_op_q;
    logic [3:0] addr_q;

    function automatic logic n_legal(input logic [3:0] n);
        return (n <= 4'd6) || (n == 4'hE) || ((n == 4'd7) && SUBN_EN);
    endfunction

    function automatic logic n_flag(input logic [3:0] n);
        return (n == 4'd4) || (n == 4'd5) || (n == 4'd6) || (n == 4'd7) || (n == 4'hE);
    endfunction

    // 8XY7 reuses SUB with operands swapped; 8XYE is SHL.
    function automatic logic [2:0] n_to_op(input logic [3:0] n);
        if (n == 4'hE)
            return 3'd7;
        else if (n == 4'd7)
            return 3'd5;
        else
            return n[2:0];
    endfunction

    assign alu_x  = alu_x_q;
    assign alu_y  = alu_y_q;
    assign alu_op = alu_op_q;

    // Next-state and port drive; rf_addr falls back to its held value.
    always_comb begin
        state_d  = state;
        busy     = (state != S_IDLE);
        done     = 1'b0;
        error    = 1'b0;
        rf_we    = 1'b0;
        rf_wdata = 8'h00;
        rf_addr  = addr_q;
        case (state)
            S_IDLE: begin
                if (start)
                    state_d = n_legal(op_n) ? S_RD_X : S_DONE;
            end
            S_RD_X: begin
                rf_addr = x_q;
                state_d = S_RD_Y;
            end
            S_RD_Y: begin
                rf_addr = y_q;
                state_d = S_CAP_Y;
            end
            S_CAP_Y: begin
                state_d = S_WB_X;
            end
            S_WB_X: begin
                rf_we    = 1'b1;
                rf_addr  = x_q;
                rf_wdata = alu_out;
                state_d  = n_flag(n_q) ? S_WB_F : S_DONE;
            end
            S_WB_F: begin
                rf_we    = 1'b1;
                rf_addr  = VF_ADDR;
                rf_wdata = {7'b0, flag_q};
                state_d  = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                error   = ~n_legal(n_q);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register plus opcode, operand and flag capture.
    // Vy is not kept separately: it lands directly in the ALU operand
    // registers, which only change on the CAP_Y -> WB_X edge so the ALU
    // inputs hold between instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            x_q      <= 4'h0;
            y_q      <= 4'h0;
            n_q      <= 4'h0;
            reg_vx   <= 8'h00;
            flag_q   <= 1'b0;
            alu_x_q  <= 8'h00;
            alu_y_q  <= 8'h00;
            alu_op_q <= 3'd0;
            addr_q   <= 4'h0;
        end else begin
            state  <= state_d;
            addr_q <= rf_addr;
            if (state == S_IDLE && start) begin
                x_q <= op_x;
                y_q <= op_y;
                n_q <= op_n;
            end
            if (state == S_RD_Y)
                reg_vx <= rf_rdata;
            if (state == S_CAP_Y) begin
                alu_op_q <= n_to_op(n_q);
                if (n_q == 4'd7) begin
                    alu_x_q <= rf_rdata;
                    alu_y_q <= reg_vx;
                end else begin
                    alu_x_q <= reg_vx;
                    alu_y_q <= rf_rdata;
                end
            end
            if (state == S_WB_X)
                flag_q <= alu_carry;
        end
    end

endmodule
